// File: rtl/xpe_result_writer.sv
// xpe_result_writer
// Packs pairs of XPE result beats into IO buffer words and writes them to
// consecutive addresses starting at a scheduler-supplied base. A transfer
// ends after a programmed number of words, or early on i_calc_end (a
// half-filled word is flushed with a zero upper half).
//
// Interface contract: there is no back-pressure. A beat is taken on every
// rising edge where i_xpe_data_valid=1. The first beat of a pair is the low
// half of the word. The word is written one cycle after its second beat is
// sampled. o_wr_en is a one-cycle strobe, and o_wr_addr/o_wr_data hold
// their last value while o_wr_en=0.
module xpe_result_writer #(
  parameter int IN_W   = 256,
  parameter int OUT_W  = 512,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr_start,
  input  logic [7:0]        i_out_piece,
  input  logic              i_calc_end,
  input  logic [IN_W-1:0]   i_xpe_data,
  input  logic              i_xpe_data_valid,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [OUT_W-1:0]  o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  // LOW: waiting for the first beat of a word; HIGH: first beat held.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // state is left at the top level so checkers can bind to it directly.
  state_t state;
  state_t state_next;

  logic [IN_W-1:0]   half_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        cnt_q;
  logic [7:0]        piece_q;
  logic [7:0]        cnt_inc;

  logic start_ok;
  logic load_half;
  logic write_word;
  logic flush_word;
  logic err_set;

  assign cnt_inc = cnt_q + 8'd1;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state and per-cycle action decode.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    load_half  = 1'b0;
    write_word = 1'b0;
    flush_word = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          start_ok   = 1'b1;
          state_next = (i_out_piece == 8'd0) ? S_DONE : S_LOW;
        end
      end
      S_LOW: begin
        // An end-of-calculation with nothing held closes the transfer;
        // a beat arriving in the same cycle has no partner and is dropped.
        if (i_calc_end) begin
          state_next = S_DONE;
        end else if (i_xpe_data_valid) begin
          load_half  = 1'b1;
          state_next = S_HIGH;
        end
      end
      S_HIGH: begin
        if (i_xpe_data_valid) begin
          write_word = 1'b1;
          state_next = (i_calc_end || (cnt_inc == piece_q)) ? S_DONE : S_LOW;
        end else if (i_calc_end) begin
          flush_word = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Beats outside a transfer and starts during one are protocol errors.
  always_comb begin
    err_set = 1'b0;
    if (i_xpe_data_valid && ((state == S_IDLE) || (state == S_DONE))) err_set = 1'b1;
    if (i_start && (state != S_IDLE)) err_set = 1'b1;
  end

  // Transfer bookkeeping: base address, word count, programmed length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      piece_q <= '0;
    end else if (start_ok) begin
      addr_q  <= i_addr_start;
      cnt_q   <= '0;
      piece_q <= i_out_piece;
    end else if (write_word || flush_word) begin
      // Address wraps naturally at 2^ADDR_W.
      addr_q <= addr_q + ADDR_W'(1);
      cnt_q  <= cnt_inc;
    end
  end

  // Holds the low half of the word being assembled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           half_q <= '0;
    else if (load_half) half_q <= i_xpe_data;
  end

  // Write port: strobe every cycle, address/data only on a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_en <= write_word || flush_word;
      if (write_word) begin
        o_wr_addr <= addr_q;
        o_wr_data <= {i_xpe_data, half_q};
      end else if (flush_word) begin
        o_wr_addr <= addr_q;
        o_wr_data <= {{IN_W{1'b0}}, half_q};
      end
    end
  end

  // Status: busy spans the transfer including DONE; done follows DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= (state == S_DONE);
      if (start_ok)               o_busy <= 1'b1;
      else if (state == S_DONE)   o_busy <= 1'b0;
    end
  end

  // Sticky error flag; an accepted start clears it unless a stray beat
  // arrives in that same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          o_err <= 1'b0;
    else if (start_ok) o_err <= i_xpe_data_valid;
    else if (err_set)  o_err <= 1'b1;
  end

endmodule

// File: tb/tb_xpe_result_writer.sv
// Bench for xpe_result_writer: directed scenarios plus randomized transfers,
// with a transaction-level model feeding expected writes and done pulses
// into queues that a negedge monitor pops and compares.
module tb_xpe_result_writer;

  localparam int IN_W   = 256;
  localparam int OUT_W  = 512;
  localparam int ADDR_W = 8;
  localparam int W      = ADDR_W + OUT_W + 32;

  logic              clk;
  logic              rst;
  logic              i_start;
  logic [ADDR_W-1:0] i_addr_start;
  logic [7:0]        i_out_piece;
  logic              i_calc_end;
  logic [IN_W-1:0]   i_xpe_data;
  logic              i_xpe_data_valid;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [OUT_W-1:0]  o_wr_data;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  xpe_result_writer #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_addr_start     (i_addr_start),
    .i_out_piece      (i_out_piece),
    .i_calc_end       (i_calc_end),
    .i_xpe_data       (i_xpe_data),
    .i_xpe_data_valid (i_xpe_data_valid),
    .o_wr_en          (o_wr_en),
    .o_wr_addr        (o_wr_addr),
    .o_wr_data        (o_wr_data),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err            (o_err)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // ---------------- scoreboard queues ----------------
  logic [W-1:0] exp_q[$];     // {addr, data, cycle}
  int           done_q[$];    // cycle at which o_done is expected

  // ---------------- reference model ----------------
  // A transfer is "active" from an accepted start until its last word (or
  // end-of-calculation); beats pair up in arrival order.
  logic              m_active;
  logic              m_half_ok;
  logic [IN_W-1:0]   m_half;
  logic [ADDR_W-1:0] m_addr;
  int                m_cnt;
  int                m_piece;
  logic              m_err;
  int                m_done_drive;

  task automatic model_reset();
    m_active     = 1'b0;
    m_half_ok    = 1'b0;
    m_half       = '0;
    m_addr       = '0;
    m_cnt        = 0;
    m_piece      = 0;
    m_err        = 1'b0;
    m_done_drive = -1;
  endtask

  task automatic push_word(input logic [OUT_W-1:0] data);
    exp_q.push_back({m_addr, data, 32'(cyc + 1)});
    m_addr = m_addr + 8'd1;
    m_cnt  = m_cnt + 1;
  endtask

  function automatic logic [IN_W-1:0] rnd_beat();
    logic [IN_W-1:0] v;
    for (int k = 0; k < IN_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0b expected %0b", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver: one clock cycle of stimulus ----------------
  task automatic step(input logic st, input logic [ADDR_W-1:0] a, input logic [7:0] p,
                      input logic ce, input logic v, input logic [IN_W-1:0] d);
    logic fin;
    fin = 1'b0;
    i_start          = st;
    i_addr_start     = a;
    i_out_piece      = p;
    i_calc_end       = ce;
    i_xpe_data_valid = v;
    i_xpe_data       = d;

    if (st && !m_active && (cyc != m_done_drive)) begin
      m_err     = v;
      m_addr    = a;
      m_piece   = int'(p);
      m_cnt     = 0;
      m_half_ok = 1'b0;
      if (p == 8'd0) fin = 1'b1;
      else           m_active = 1'b1;
    end else begin
      if (st) m_err = 1'b1;
      if (m_active) begin
        if (ce && !m_half_ok) begin
          fin = 1'b1;
        end else if (v) begin
          if (!m_half_ok) begin
            m_half    = d;
            m_half_ok = 1'b1;
          end else begin
            push_word({d, m_half});
            m_half_ok = 1'b0;
            if (ce || (m_cnt == m_piece)) fin = 1'b1;
          end
        end else if (ce) begin
          push_word({{IN_W{1'b0}}, m_half});
          m_half_ok = 1'b0;
          fin       = 1'b1;
        end
      end else if (v) begin
        m_err = 1'b1;
      end
    end
    if (fin) begin
      m_active     = 1'b0;
      m_done_drive = cyc + 1;
      done_q.push_back(cyc + 2);
    end

    @(posedge clk);
    #1;
    i_start          = 1'b0;
    i_calc_end       = 1'b0;
    i_xpe_data_valid = 1'b0;
    check_bit("err", o_err, m_err);
    check_bit("busy", o_busy, m_active || fin);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 8'd0, 1'b0, 1'b0, '0);
  endtask

  task automatic start(input logic [ADDR_W-1:0] a, input logic [7:0] p);
    step(1'b1, a, p, 1'b0, 1'b0, '0);
  endtask

  task automatic beat(input logic [IN_W-1:0] d);
    step(1'b0, '0, 8'd0, 1'b0, 1'b1, d);
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_wr_en"}, o_wr_en, 1'b0);
    check_bit({tag, "_wr_addr_zero"}, (o_wr_addr == '0), 1'b1);
    check_bit({tag, "_wr_data_zero"}, (o_wr_data == '0), 1'b1);
    check_bit({tag, "_busy"}, o_busy, 1'b0);
    check_bit({tag, "_done"}, o_done, 1'b0);
    check_bit({tag, "_err"}, o_err, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (o_wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write at cycle %0d: addr=%0h, no write expected", cyc, o_wr_addr);
        end else begin
          logic [W-1:0]      e;
          logic [ADDR_W-1:0] ea;
          logic [OUT_W-1:0]  ed;
          int                ec;
          e  = exp_q.pop_front();
          ea = e[W-1 -: ADDR_W];
          ed = e[32 +: OUT_W];
          ec = int'(e[31:0]);
          if (o_wr_addr !== ea || o_wr_data !== ed || cyc != ec) begin
            failures++;
            $display("FAIL write: got addr=%0h cyc=%0d data=%h expected addr=%0h cyc=%0d data=%h",
                     o_wr_addr, cyc, o_wr_data, ea, ec, ed);
          end
        end
      end
      if (o_done) begin
        checks++;
        if (done_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          int dc;
          dc = done_q.pop_front();
          if (cyc != dc || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL done: got cycle=%0d busy=%0b expected cycle=%0d busy=0", cyc, o_busy, dc);
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst              = 1'b0;
    i_start          = 1'b0;
    i_addr_start     = '0;
    i_out_piece      = '0;
    i_calc_end       = 1'b0;
    i_xpe_data       = '0;
    i_xpe_data_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Normal pack: {5,3} @0x10, {9,7} @0x11
    start(8'h10, 8'd2);
    beat(256'd3); beat(256'd5); beat(256'd7); beat(256'd9);
    idle(3);

    // Gapped valid
    start(8'h20, 8'd1);
    beat(256'hA); idle(3); beat(256'hB);
    idle(3);

    // Flush of a half-filled word
    start(8'h30, 8'd4);
    beat(256'd1); beat(256'd2); beat(256'd3);
    step(1'b0, '0, 8'd0, 1'b1, 1'b0, '0);
    idle(3);

    // Address wrap, then zero-length transfer
    start(8'hFF, 8'd2);
    beat(256'd11); beat(256'd12); beat(256'd13); beat(256'd14);
    idle(3);
    start(8'h77, 8'd0);
    idle(3);

    // Errors: stray beat, then start while busy, then clearing start
    beat(256'd99);
    idle(1);
    start(8'h40, 8'd2);
    beat(256'd21);
    start(8'h90, 8'd1);
    beat(256'd22); beat(256'd23); beat(256'd24);
    idle(3);
    start(8'h48, 8'd1);
    beat(256'd25); beat(256'd26);
    idle(3);

    // Async reset while holding a first beat
    start(8'h50, 8'd2);
    beat(256'd31);
    rst = 1'b0;
    #2;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    start(8'h60, 8'd1);
    beat(256'd41); beat(256'd42);
    idle(3);

    // Randomized transfers, some ended early by i_calc_end
    for (int t = 0; t < 40; t++) begin
      int piece;
      int nbeats;
      int cut;
      piece  = $urandom_range(1, 5);
      nbeats = 2 * piece;
      cut    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, nbeats - 1) : nbeats;
      start(ADDR_W'($urandom_range(0, 255)), 8'(piece));
      for (int b = 0; b < cut; b++) begin
        int gap;
        gap = $urandom_range(0, 3);
        if (gap > 2) gap = 0;
        idle(gap);
        if (b == cut - 1 && cut < nbeats && $urandom_range(0, 1) == 1)
          step(1'b0, '0, 8'd0, 1'b1, 1'b1, rnd_beat());
        else
          beat(rnd_beat());
      end
      if (cut < nbeats && m_active) step(1'b0, '0, 8'd0, 1'b1, 1'b0, '0);
      idle(3);
    end

    idle(4);
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: got writes=%0d dones=%0d pending, expected 0 and 0",
               exp_q.size(), done_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xpe_result_writer.md
Name: xpe_result_writer

Overview:
- Write-side consumer of the XPE output stream. Sits between XPE and the IO buffer write port.
- Accepts 256-bit XPE result beats (o_xpe_data_out / o_xpe_data_valid) and packs beat pairs into 512-bit IO buffer words.
- Generates sequential write addresses from a decoder-supplied start address.
- Signals completion after a programmed number of words has been written.

Parameters:
- IN_W, 256, XPE result beat width
- OUT_W, 512, IO buffer word width (fixed at 2*IN_W)
- ADDR_W, 8, IO buffer write address width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle start pulse from scheduler
- i_addr_start  in  ADDR_W  first IO buffer word address, sampled on i_start
- i_out_piece  in  8  number of 512-bit words to write, sampled on i_start
- i_calc_end  in  1  end-of-calculation pulse from Oagu; forces flush of a half-filled word
- i_xpe_data  in  IN_W  XPE result beat
- i_xpe_data_valid  in  1  beat qualifier
- o_wr_en  out  1  IO buffer write strobe
- o_wr_addr  out  ADDR_W  IO buffer write address
- o_wr_data  out  OUT_W  packed word: {second beat, first beat}
- o_busy  out  1  high from accepted start until done
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  sticky error flag; cleared only by reset or an accepted i_start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output register 0, i.e. o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_err=0. Internal half-word register, word counter and piece register also 0. Reset mid-transfer aborts with no write and no done pulse.
- States: IDLE, LOW (waiting for first beat of a word), HIGH (first beat held, waiting for second), DONE.
- IDLE:
  - i_start=1 latches i_addr_start into the address counter and i_out_piece into the piece register, clears the word counter and o_err, sets o_busy, and moves to LOW.
  - If i_out_piece=0, go directly to DONE instead; no writes occur.
- LOW: a valid beat stores i_xpe_data in the half register and moves to HIGH.
- HIGH: a valid beat produces a word. On the next edge: o_wr_en=1, o_wr_data={i_xpe_data, half}, o_wr_addr=current address. The address counter increments and the word counter increments.
  - If the incremented word count equals the piece register, go to DONE.
  - Otherwise return to LOW.
- Write latency: exactly 1 cycle after the second beat is sampled. o_wr_en is high for exactly one cycle per word. Back-to-back valid beats give one write every 2 cycles. Gaps in valid stall without penalty.
- i_calc_end:
  - In HIGH, with no valid that cycle: write {IN_W'0, half} next cycle (counts as a word), then go to DONE regardless of count.
  - In HIGH, with valid that same cycle: treat as a normal second beat and go to DONE after the write.
  - In LOW: go to DONE with no write.
  - In IDLE or DONE: ignored.
- DONE: lasts one cycle. o_done=1 for that cycle and o_busy falls with it (o_busy=0 when o_done=1). Then IDLE.
- Address arithmetic: the counter is ADDR_W bits and wraps modulo 2^ADDR_W (0xFF+1 -> 0x00). This is not an error.
- Error cases (o_err set, sticky):
  - i_xpe_data_valid while in IDLE or DONE; the beat is discarded.
  - i_start while busy; it is ignored and the transfer continues unchanged.
- Simultaneous i_start and i_xpe_data_valid in IDLE: the start is accepted, the beat is discarded, and o_err is set.
- Word counter width is 8 bits; 255 words maximum per transfer.
- o_wr_data holds its last value when o_wr_en=0.

Test Plan:
- Normal pack: start, addr_start=0x10, out_piece=2; beats 3,5,7,9 on consecutive cycles -> writes at 0x10 data {5,3} and 0x11 data {9,7}, each 1 cycle after the second beat; o_done pulses 1 cycle after the last write; o_busy falls with o_done.
- Gapped valid: out_piece=1; beat 0xA, 3 idle cycles, beat 0xB -> single write {0xB,0xA} at addr_start, 1 cycle after 0xB; no other o_wr_en.
- Flush: out_piece=4; beats 1,2,3 then i_calc_end with no valid -> writes {2,1} at A and {0,3} at A+1, then o_done; o_err=0.
- Wrap and zero: addr_start=0xFF, out_piece=2, 4 beats -> writes at 0xFF then 0x00. Separately, out_piece=0 -> o_done 1 cycle after start, no write.
- Errors: valid beat in IDLE -> o_err=1, no write; then i_start while busy -> ignored, original addresses kept; the next accepted start clears o_err.
- Async reset: assert rst=0 mid-word while in HIGH -> all outputs 0 immediately without a clock edge; after release, a new start writes from the new addr_start with a correct pairing.
